// File: rtl/detect_stream_ctrl.sv
// Serializes a word MSB-first into an external 1001 Mealy detector and counts its hits.
// Optional build macro DETECT_CHAIN_EN skips the detector-clear cycle so detector state carries across words.
module detect_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             det_rst,
    output logic             det_x,
    input  logic             det_z,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    // state | meaning
    // IDLE  | waiting for a word, in_ready high
    // CLEAR | one cycle of det_rst before streaming
    // SHIFT | one bit per cycle to the detector, hits counted
    // DONE  | one-cycle done pulse, count held
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
        end else if (abort && state != IDLE) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort in IDLE blocks the handshake
                    if (in_valid && !abort) begin
                        sreg    <= in_data;
                        bit_cnt <= '0;
                        cnt     <= '0;
`ifdef DETECT_CHAIN_EN
                        state   <= SHIFT;
`else
                        state   <= CLEAR;
`endif
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    if (det_z && cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign det_rst   = reset | (state == CLEAR);
    assign det_x     = (state == SHIFT) & sreg[WIDTH-1];
    assign done      = (state == DONE);
    assign match_cnt = cnt;

endmodule

// File: tb/tb_detect_stream_ctrl.sv
// Directed bench for detect_stream_ctrl with a behavioural 1001 Mealy detector and a count scoreboard.
module tb_detect_stream_ctrl;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             abort;
    logic [WIDTH-1:0] in_data;

    logic       in_ready0, det_rst0, det_x0, det_z0, done0;
    logic [3:0] cnt0;
    logic       in_ready1, det_rst1, det_x1, det_z1, done1;
    logic [0:0] cnt1;
    logic [1:0] ds0, ds1;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];

    always #5 clock = ~clock;

    detect_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .abort(abort), .det_rst(det_rst0), .det_x(det_x0),
        .det_z(det_z0), .done(done0), .match_cnt(cnt0)
    );

    detect_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(1)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .abort(abort), .det_rst(det_rst1), .det_x(det_x1),
        .det_z(det_z1), .done(done1), .match_cnt(cnt1)
    );

    // states: 0 none, 1 "1", 2 "10", 3 "100"; overlapping
    function automatic logic [1:0] det_next(logic [1:0] s, logic x);
        case (s)
            2'd0:    return x ? 2'd1 : 2'd0;
            2'd1:    return x ? 2'd1 : 2'd2;
            2'd2:    return x ? 2'd1 : 2'd3;
            default: return x ? 2'd1 : 2'd0;
        endcase
    endfunction

    always_ff @(posedge clock or posedge det_rst0) begin
        if (det_rst0) ds0 <= 2'd0;
        else          ds0 <= det_next(ds0, det_x0);
    end
    always_ff @(posedge clock or posedge det_rst1) begin
        if (det_rst1) ds1 <= 2'd0;
        else          ds1 <= det_next(ds1, det_x1);
    end
    assign det_z0 = (ds0 == 2'd3) & det_x0;
    assign det_z1 = (ds1 == 2'd3) & det_x1;

    function automatic int exp_count(logic [WIDTH-1:0] w, int cw);
        logic [1:0] s = 2'd0;
        int c = 0;
        int mx = (1 << cw) - 1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (s == 2'd3 && w[i] && c < mx) c++;
            s = det_next(s, w[i]);
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input string name);
        int n;
        int e0;
        int e1;
        check({name, "_ready_idle"}, {31'd0, in_ready0}, 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        q0.push_back(exp_count(w, 4));
        q1.push_back(exp_count(w, 1));
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = '0;
        check({name, "_clear_detrst"}, {31'd0, det_rst0}, 32'd1);
        check({name, "_clear_ready"}, {31'd0, in_ready0}, 32'd0);
        check({name, "_clear_cnt"}, {28'd0, cnt0}, 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clock);
            check($sformatf("%s_detx%0d", name, i), {31'd0, det_x0}, {31'd0, w[WIDTH-1-i]});
            check($sformatf("%s_nodone%0d", name, i), {31'd0, done0 | det_rst0}, 32'd0);
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done0 && n < 12);
        check({name, "_done_seen"}, {31'd0, done0}, 32'd1);
        check({name, "_latency"}, WIDTH + n, WIDTH + 1);
        check({name, "_done_sat"}, {31'd0, done1}, 32'd1);
        check({name, "_done_ready"}, {31'd0, in_ready0}, 32'd0);
        if (q0.size() == 0 || q1.size() == 0) begin
            check({name, "_sb_empty"}, q0.size() + q1.size(), 32'd2);
        end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check({name, "_cnt"}, {28'd0, cnt0}, e0);
            check({name, "_cnt_sat"}, {31'd0, cnt1}, e1);
            @(negedge clock);
            check({name, "_pulse_end"}, {31'd0, done0}, 32'd0);
            check({name, "_ready_back"}, {31'd0, in_ready0}, 32'd1);
            check({name, "_cnt_hold"}, {28'd0, cnt0}, e0);
        end
    endtask

    initial begin
        int nd;
        reset    = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        in_data  = '0;
        #1;
        check("rst_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_detrst", {31'd0, det_rst0}, 32'd1);
        check("rst_detx", {31'd0, det_x0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_cnt", {28'd0, cnt0}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_detrst", {31'd0, det_rst0}, 32'd0);
        @(negedge clock);

        send_word(8'b1001_1001, "w99");
        send_word(8'b1001_0010, "w92");
        send_word(8'b0000_0001, "w01");
        send_word(8'b0010_0000, "w20");
        send_word(8'b1111_0000, "wf0");

        // abort while idle blocks the handshake
        in_valid = 1'b1;
        in_data  = 8'b1001_1001;
        abort    = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        abort    = 1'b0;
        check("idle_abort_ready", {31'd0, in_ready0}, 32'd1);
        check("idle_abort_detrst", {31'd0, det_rst0}, 32'd0);
        @(negedge clock);

        // abort in 3rd SHIFT cycle
        in_valid = 1'b1;
        in_data  = 8'b1001_1001;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort3_ready", {31'd0, in_ready0}, 32'd1);
        check("abort3_cnt", {28'd0, cnt0}, 32'd0);
        check("abort3_detx", {31'd0, det_x0}, 32'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clock);
            if (done0) nd++;
        end
        check("abort3_nodone", nd, 32'd0);

        // abort after one hit has been counted
        in_valid = 1'b1;
        in_data  = 8'b1001_0010;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("abort6_precnt", {28'd0, cnt0}, 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort6_cnt", {28'd0, cnt0}, 32'd0);
        check("abort6_ready", {31'd0, in_ready0}, 32'd1);
        check("abort6_done", {31'd0, done0}, 32'd0);
        @(negedge clock);

        // reset in 5th SHIFT cycle
        in_valid = 1'b1;
        in_data  = 8'b1001_1001;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_pre_detx", {31'd0, det_x0}, 32'd1);
        check("midrst_pre_cnt", {28'd0, cnt0}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_detx", {31'd0, det_x0}, 32'd0);
        check("midrst_detrst", {31'd0, det_rst0}, 32'd1);
        check("midrst_cnt", {28'd0, cnt0}, 32'd0);
        check("midrst_ready", {31'd0, in_ready0}, 32'd1);
        check("midrst_done", {31'd0, done0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_rel_ready", {31'd0, in_ready0}, 32'd1);
        nd = 0;
        repeat (12) begin
            @(negedge clock);
            if (done0) nd++;
        end
        check("midrst_nodone", nd, 32'd0);
        send_word(8'b1001_0010, "after_rst");

        check("sb_drained", q0.size() + q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
